// File: rtl/rv_ifu_fetch_fifo.sv
// Instruction fetch buffer: a small first-word-fall-through FIFO of
// {pc, instr} pairs sitting between the instruction-memory response path
// and the IF/ID register. Absorbs decode stalls and drops everything on a
// pipeline redirect (flush).
module rv_ifu_fetch_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_pc,
    input  logic [DW-1:0]          in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_pc,
    output logic [DW-1:0]          out_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so that full and empty are distinguishable.
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [DW-1:0] pc_mem    [DEPTH];
    logic [DW-1:0] instr_mem [DEPTH];

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];

    // Status, handshakes and head-entry read; in_ready depends only on state,
    // keeping out_ready off any combinational path to in_ready.
    always_comb begin
        empty     = (wr_ptr_reg == rd_ptr_reg);
        full      = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        count     = wr_ptr_reg - rd_ptr_reg;
        out_pc    = pc_mem[rd_idx];
        out_instr = instr_mem[rd_idx];
    end

    // Pointer update: flush overrides any push/pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Per-entry storage; entries reset to zero so the head outputs are never X.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the incoming beat into this slot when it is the write target.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pc_mem[gi]    <= '0;
                    instr_mem[gi] <= '0;
                end else if (push && !flush && (wr_idx == AW'(gi))) begin
                    pc_mem[gi]    <= in_pc;
                    instr_mem[gi] <= in_instr;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rv_ifu_fetch_fifo.sv
// Directed self-checking bench for rv_ifu_fetch_fifo (DW=32, DEPTH=4).
module tb_rv_ifu_fetch_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    rv_ifu_fetch_fifo #(.DW(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ~pc;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] exp_order [5];
    int          k;
    bit          accepted;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #3;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        step();
        rst = 1'b0;

        // Single beat: not visible in the push cycle, visible the next.
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_instr = 32'h0000_0013;
        chk("t1_push_cycle_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_pc", out_pc, 32'h8000_0000);
        chk("t1_out_instr", out_instr, 32'h0000_0013);
        chk("t1_count", count, 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t1_drained", count, 0);

        // Fill to DEPTH, fifth beat held upstream.
        for (int i = 0; i < 4; i++) begin
            chk("t2_in_ready_fill", in_ready, 1);
            push_one(32'(i * 4));
        end
        chk("t2_full_in_ready", in_ready, 0);
        chk("t2_full_count", count, 4);
        in_valid = 1'b1; in_pc = 32'h10; in_instr = ~32'h10;
        step();
        chk("t2_held_count", count, 4);
        exp_order[0] = 32'h0; exp_order[1] = 32'h4; exp_order[2] = 32'h8;
        exp_order[3] = 32'hC; exp_order[4] = 32'h10;
        out_ready = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 12 && k < 5; cyc++) begin
            accepted = in_valid && in_ready;
            if (out_valid) begin
                chk("t2_pop_order", out_pc, exp_order[k]);
                k++;
            end
            step();
            if (accepted) in_valid = 1'b0;
        end
        chk("t2_pops_seen", k, 5);
        chk("t2_empty_after", count, 0);
        out_ready = 1'b0;

        // Streaming across pointer wraps.
        out_ready = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            in_valid = (j < 12);
            in_pc    = 32'h100 + 32'(4 * j);
            in_instr = ~in_pc;
            if (j == 0) begin
                chk("t3_first_valid", out_valid, 0);
            end else begin
                chk("t3_stream_pc", out_pc, 32'h100 + 32'(4 * (j - 1)));
                chk("t3_stream_count", count, 1);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t3_empty_after", count, 0);

        // Simultaneous push and pop at count=2.
        push_one(32'h400);
        push_one(32'h404);
        chk("t4_count_before", count, 2);
        in_valid = 1'b1; in_pc = 32'h408; in_instr = ~32'h408; out_ready = 1'b1;
        chk("t4_head_before", out_pc, 32'h400);
        step();
        in_valid = 1'b0;
        chk("t4_count_after", count, 2);
        chk("t4_head_after", out_pc, 32'h404);
        step(); step();
        out_ready = 1'b0;
        chk("t4_drained", count, 0);

        // Flush with coincident push and pop.
        push_one(32'h500); push_one(32'h504); push_one(32'h508);
        chk("t5_count_before", count, 3);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_instr = ~32'h200; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_count_flushed", count, 0);
        chk("t5_out_valid_flushed", out_valid, 0);
        chk("t5_in_ready_flushed", in_ready, 1);
        push_one(32'h300);
        chk("t5_new_head", out_pc, 32'h300);
        chk("t5_new_count", count, 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t5_no_stale", out_valid, 0);

        // Asynchronous reset between edges.
        push_one(32'h600); push_one(32'h604); push_one(32'h608);
        chk("t6_count_before", count, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_out_valid", out_valid, 0);
        chk("t6_async_out_pc", out_pc, 0);
        chk("t6_async_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        push_one(32'h700);
        chk("t6_resume_pc", out_pc, 32'h700);
        chk("t6_resume_count", count, 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t6_resume_drained", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
